snake_grid_engine: RTL

//  Parametrised snake body store and pixel colour source for a GRID_W x GRID_H WS2812 matrix.

---
 rtl/snake_pkg.sv | 50 +++++
 rtl/snake_body_fifo.sv | 49 ++++
 rtl/snake_grid_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types, default colours and grid index helpers for the snake engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  localparam logic [23:0] DEF_BODY_GRB = 24'h880000;
  localparam logic [23:0] DEF_FOOD_GRB = 24'h008800;
  localparam logic [23:0] DEF_HEAD_GRB = 24'h888800;

  function automatic int unsigned idx_row(input int unsigned idx, input int unsigned w);
    return idx / w;
  endfunction

  function automatic int unsigned idx_col(input int unsigned idx, input int unsigned w);
    return idx % w;
  endfunction

  function automatic int unsigned coord_idx(input int unsigned row, input int unsigned col,
                                            input int unsigned w);
    return row * w + col;
  endfunction

  // Neighbour of idx in direction dir on a w x h torus.
  function automatic int unsigned wrap_step(input int unsigned idx, input dir_e dir,
                                            input int unsigned w, input int unsigned h);
    int unsigned row;
    int unsigned col;
    row = idx_row(idx, w);
    col = idx_col(idx, w);
    case (dir)
      DIR_UP:   row = (row == 32'd0)   ? h - 32'd1 : row - 32'd1;
      DIR_DOWN: row = (row == h - 32'd1) ? 32'd0   : row + 32'd1;
      DIR_LEFT: col = (col == 32'd0)   ? w - 32'd1 : col - 32'd1;
      default:  col = (col == w - 32'd1) ? 32'd0   : col + 32'd1;
    endcase
    return coord_idx(row, col, w);
  endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cell indices; head is the newest entry, tail the oldest.
module snake_body_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [DW-1:0] o_tail
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_last_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_last_ptr = (r_wr_ptr == '0) ? PTR_W'(DEPTH - 1) : r_wr_ptr - PTR_W'(1);
  assign o_head     = r_mem[w_last_ptr];
  assign o_tail     = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/snake_grid_engine.sv
// Snake body store, movement/collision FSM and GRB pixel source for a WS2812 grid.
// Optional build macro SNAKE_HEAD_COLOR_EN: the head cell reads HEAD_GRB instead of BODY_GRB.
module snake_grid_engine
  import snake_pkg::*;
#(
  parameter  int unsigned GRID_W    = 8,
  parameter  int unsigned GRID_H    = 8,
  parameter  int unsigned MAX_LEN   = 16,
  parameter  int unsigned INIT_LEN  = 3,
  parameter  int unsigned START_IDX = 0,
  parameter  logic [23:0] BODY_GRB  = DEF_BODY_GRB,
  parameter  logic [23:0] FOOD_GRB  = DEF_FOOD_GRB,
  parameter  logic [23:0] HEAD_GRB  = DEF_HEAD_GRB,
  localparam int unsigned IDX_W     = $clog2(GRID_W * GRID_H),
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             restart,
  input  logic             step,
  input  logic [1:0]       dir,
  input  logic             grow,
  input  logic [IDX_W-1:0] food_idx,
  input  logic             food_vld,
  input  logic             pix_rd,
  input  logic [IDX_W-1:0] pix_idx,
  output logic             pix_vld,
  output logic [23:0]      pix_grb,
  output logic [IDX_W-1:0] head_idx,
  output logic [LEN_W-1:0] snake_len,
  output logic             busy,
  output logic             step_done,
  output logic             self_hit
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
`ifdef SNAKE_HEAD_COLOR_EN
  localparam bit HEAD_EN = 1'b1;
`else
  localparam bit HEAD_EN = 1'b0;
`endif

  state_e           r_state, w_state_nxt;
  logic [CELLS-1:0] r_bitmap;
  logic [LEN_W-1:0] r_init_cnt, r_len;
  logic [IDX_W-1:0] r_head_idx;
  logic             r_busy, r_step_done, r_self_hit, r_pix_vld;
  logic [23:0]      r_pix_grb;

  logic [IDX_W-1:0] w_fifo_head, w_tail, w_next, w_init_cell, w_push_data;
  logic             w_eff_grow, w_hit, w_pop, w_pix_in;
  logic             w_init_wr, w_init_last, w_step_ok, w_hit_ev;
  logic [23:0]      w_pix_col;

  assign w_init_cell = IDX_W'(START_IDX) + IDX_W'(r_init_cnt);
  assign w_next      = IDX_W'(wrap_step(32'(w_fifo_head), dir_e'(dir), GRID_W, GRID_H));
  assign w_eff_grow  = grow && (r_len < LEN_W'(MAX_LEN));
  // Moving onto the tail is legal when the tail is vacated in the same step.
  assign w_hit       = r_bitmap[w_next] && !((w_next == w_tail) && !w_eff_grow);
  assign w_pop       = w_step_ok && !w_eff_grow;
  assign w_push_data = w_init_wr ? w_init_cell : w_next;

  snake_body_fifo #(
    .DEPTH (MAX_LEN),
    .DW    (IDX_W)
  ) u_body (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .i_clr       (restart),
    .i_push      (w_init_wr | w_step_ok),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_tail      (w_tail)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_INIT;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_INIT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_init_last = 1'b0;
    w_step_ok   = 1'b0;
    w_hit_ev    = 1'b0;
    if (restart) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT: begin
          w_init_wr = 1'b1;
          if (r_init_cnt == LEN_W'(INIT_LEN - 1)) begin
            w_init_last = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (step && !r_step_done) begin
            if (w_hit) begin
              w_hit_ev    = 1'b1;
              w_state_nxt = S_DEAD;
            end else begin
              w_step_ok = 1'b1;
            end
          end
        end
        S_DEAD:  w_state_nxt = S_DEAD;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  // Body bitmap, length, head and status flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bitmap    <= '0;
      r_init_cnt  <= '0;
      r_len       <= '0;
      r_head_idx  <= '0;
      r_step_done <= 1'b0;
      r_self_hit  <= 1'b0;
    end else if (restart) begin
      r_bitmap    <= '0;
      r_init_cnt  <= '0;
      r_len       <= '0;
      r_head_idx  <= '0;
      r_step_done <= 1'b0;
      r_self_hit  <= 1'b0;
    end else begin
      r_step_done <= w_step_ok;
      if (w_init_wr) begin
        r_bitmap[w_init_cell] <= 1'b1;
        r_init_cnt            <= w_init_last ? '0 : r_init_cnt + LEN_W'(1);
      end
      if (w_init_last) begin
        r_len      <= LEN_W'(INIT_LEN);
        r_head_idx <= w_init_cell;
      end
      if (w_hit_ev) r_self_hit <= 1'b1;
      if (w_step_ok) begin
        // Tail clear first so that a move onto the old tail leaves the bit set.
        if (w_pop) r_bitmap[w_tail] <= 1'b0;
        r_bitmap[w_next] <= 1'b1;
        r_len            <= r_len + LEN_W'(w_eff_grow);
        r_head_idx       <= w_next;
      end
    end
  end

  generate
    if (CELLS == (1 << IDX_W)) begin : g_pix_full
      assign w_pix_in = 1'b1;
    end else begin : g_pix_part
      assign w_pix_in = (pix_idx < IDX_W'(CELLS));
    end
  endgenerate

  always_comb begin
    w_pix_col = '0;
    if (w_pix_in) begin
      if (r_bitmap[pix_idx]) begin
        w_pix_col = (HEAD_EN && (pix_idx == r_head_idx)) ? HEAD_GRB : BODY_GRB;
      end else if (food_vld && (food_idx == pix_idx)) begin
        w_pix_col = FOOD_GRB;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_vld <= 1'b0;
      r_pix_grb <= '0;
    end else begin
      r_pix_vld <= pix_rd;
      if (pix_rd) r_pix_grb <= w_pix_col;
    end
  end

  assign pix_vld   = r_pix_vld;
  assign pix_grb   = r_pix_grb;
  assign head_idx  = r_head_idx;
  assign snake_len = r_len;
  assign busy      = r_busy;
  assign step_done = r_step_done;
  assign self_hit  = r_self_hit;

endmodule
